// File: rtl/vcpu_pkg.sv
// Shared definitions for the vcpu memory path: transaction mode/scale codes
// and the memory-responder state encoding.
package vcpu_pkg;

   localparam logic       MEM_MODE_READ  = 1'b0;
   localparam logic       MEM_MODE_WRITE = 1'b1;

   localparam logic [1:0] MEM_SCALE_8BIT  = 2'b00;
   localparam logic [1:0] MEM_SCALE_16BIT = 2'b01;
   localparam logic [1:0] MEM_SCALE_32BIT = 2'b10;
   localparam logic [1:0] MEM_SCALE_RSVD  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } mem_state_t;

endpackage

// File: rtl/vmem_lane_align.sv
// Byte-lane steering between a 32-bit RAM word and 8/16/32-bit transactions:
// read extraction with zero/sign extension, write byte enables and lane replication.
module vmem_lane_align
   import vcpu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [1:0]  scale,
   input  logic        is_signed,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wword
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      rd_byte = word[7:0];
      case (lane)
         2'd0:    rd_byte = word[7:0];
         2'd1:    rd_byte = word[15:8];
         2'd2:    rd_byte = word[23:16];
         default: rd_byte = word[31:24];
      endcase
      rd_half = lane[1] ? word[31:16] : word[15:0];
   end

   // Write data is replicated across all lanes; the byte enables pick the live ones.
   always_comb begin
      rdata = 32'h0;
      be    = 4'b0000;
      wword = wdata;
      case (scale)
         MEM_SCALE_8BIT: begin
            rdata = {{24{is_signed & rd_byte[7]}}, rd_byte};
            be    = 4'b0001 << lane;
            wword = {4{wdata[7:0]}};
         end
         MEM_SCALE_16BIT: begin
            rdata = {{16{is_signed & rd_half[15]}}, rd_half};
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wword = {2{wdata[15:0]}};
         end
         MEM_SCALE_32BIT: begin
            rdata = word;
            be    = 4'b1111;
            wword = wdata;
         end
         default: begin
            rdata = 32'h0;
            be    = 4'b0000;
            wword = wdata;
         end
      endcase
   end

endmodule

// File: rtl/vmem_port.sv
// Data-memory responder: one transaction at a time over a toggle handshake,
// word-organised local RAM, 8/16/32-bit accesses with fault reporting.
module vmem_port
   import vcpu_pkg::*;
#(
   parameter int ADDR_BITS = 10,  // must be < 32
   parameter int LATENCY   = 1    // 1..15 cycles in ACCESS
)(
   input  logic        sck,
   input  logic        rst,
   input  logic        mem_req,
   input  logic        mem_mode,
   input  logic [1:0]  mem_scale,
   input  logic        mem_is_signed,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_ack,
   output logic [31:0] mem_rdata,
   output logic        mem_fault,
   output logic        busy,
   output mem_state_t  state
);

   // Handshake: a request is pending while mem_req != mem_ack. The responder
   // samples the request fields only on the capture edge in IDLE and answers by
   // toggling mem_ack, with mem_rdata/mem_fault updated on that same edge.

   localparam int         DEPTH    = 1 << (ADDR_BITS - 2);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   mem_state_t  state_r, state_nxt;
   logic        mode_q;
   logic [1:0]  scale_q;
   logic        signed_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  cnt;
   logic [31:0] rdata_nxt;
   logic        fault_nxt;

   logic        pending;
   logic        fault_hit;
   logic        ram_we;
   logic [ADDR_BITS-3:0] word_idx;
   logic [31:0] ram_word;
   logic [31:0] rd_ext;
   logic [3:0]  wr_be;
   logic [31:0] wr_word;

   logic [31:0] ram [DEPTH];

   assign state    = state_r;
   assign pending  = (mem_req != mem_ack);
   assign word_idx = addr_q[ADDR_BITS-1:2];
   assign ram_word = ram[word_idx];

   always_comb begin
      fault_hit = 1'b0;
      if (scale_q == MEM_SCALE_RSVD)                          fault_hit = 1'b1;
      if ((scale_q == MEM_SCALE_16BIT) && addr_q[0])          fault_hit = 1'b1;
      if ((scale_q == MEM_SCALE_32BIT) && (addr_q[1:0] != 0)) fault_hit = 1'b1;
      if (|addr_q[31:ADDR_BITS])                              fault_hit = 1'b1;
   end

   vmem_lane_align u_align (
      .word      (ram_word),
      .lane      (addr_q[1:0]),
      .scale     (scale_q),
      .is_signed (signed_q),
      .wdata     (wdata_q),
      .rdata     (rd_ext),
      .be        (wr_be),
      .wword     (wr_word)
   );

   always_ff @(posedge sck or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_nxt;
   end

   always_comb begin
      state_nxt = state_r;
      ram_we    = 1'b0;
      case (state_r)
         ST_IDLE:   if (pending) state_nxt = ST_CHECK;
         ST_CHECK:  state_nxt = fault_hit ? ST_RESP : ST_ACCESS;
         ST_ACCESS: begin
            if (cnt == 4'd0) begin
               state_nxt = ST_RESP;
               ram_we    = (mode_q == MEM_MODE_WRITE);
            end
         end
         ST_RESP:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge sck or posedge rst) begin
      if (rst) begin
         mem_ack   <= 1'b0;
         mem_rdata <= 32'h0;
         mem_fault <= 1'b0;
         busy      <= 1'b0;
         cnt       <= 4'd0;
         rdata_nxt <= 32'h0;
         fault_nxt <= 1'b0;
         mode_q    <= MEM_MODE_READ;
         scale_q   <= MEM_SCALE_8BIT;
         signed_q  <= 1'b0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pending) begin
                  mode_q   <= mem_mode;
                  scale_q  <= mem_scale;
                  signed_q <= mem_is_signed;
                  addr_q   <= mem_addr;
                  wdata_q  <= mem_wdata;
                  busy     <= 1'b1;
               end
            end
            ST_CHECK: begin
               if (fault_hit) begin
                  fault_nxt <= 1'b1;
                  rdata_nxt <= 32'h0;
               end else begin
                  cnt <= CNT_INIT;
               end
            end
            ST_ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  fault_nxt <= 1'b0;
                  rdata_nxt <= (mode_q == MEM_MODE_READ) ? rd_ext : 32'h0;
               end
            end
            ST_RESP: begin
               mem_ack   <= ~mem_ack;
               mem_rdata <= rdata_nxt;
               mem_fault <= fault_nxt;
               busy      <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // RAM is not reset; the write enable is already cleared by the async reset of state_r.
   always_ff @(posedge sck) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) ram[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_vmem_port.sv
// Directed, table-driven bench for vmem_port: one instance at LATENCY=1 and one
// at LATENCY=4 for the latency and reset-mid-transaction cases.
module tb_vmem_port;
   import vcpu_pkg::*;

   typedef struct {
      string       name;
      logic        mode;
      logic [1:0]  scale;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_fault;
      int          exp_lat;
   } vec_t;

   logic        sck = 1'b0;
   logic        a_rst, b_rst;
   logic        a_req, a_mode, a_sgn, b_req, b_mode, b_sgn;
   logic [1:0]  a_scale, b_scale;
   logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
   logic        a_ack, a_fault, a_busy, b_ack, b_fault, b_busy;
   logic [31:0] a_rdata, b_rdata;
   mem_state_t  a_state, b_state;

   int checks = 0;
   int passed = 0;
   vec_t tbl[$];

   always #5 sck = ~sck;

   vmem_port #(.ADDR_BITS(10), .LATENCY(1)) dut_a (
      .sck(sck), .rst(a_rst), .mem_req(a_req), .mem_mode(a_mode), .mem_scale(a_scale),
      .mem_is_signed(a_sgn), .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_ack(a_ack),
      .mem_rdata(a_rdata), .mem_fault(a_fault), .busy(a_busy), .state(a_state)
   );

   vmem_port #(.ADDR_BITS(10), .LATENCY(4)) dut_b (
      .sck(sck), .rst(b_rst), .mem_req(b_req), .mem_mode(b_mode), .mem_scale(b_scale),
      .mem_is_signed(b_sgn), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_ack(b_ack),
      .mem_rdata(b_rdata), .mem_fault(b_fault), .busy(b_busy), .state(b_state)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic vec_t mk(input string name, input logic mode, input logic [1:0] scale,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_fault, input int exp_lat);
      vec_t v;
      v.name = name; v.mode = mode; v.scale = scale; v.sgn = sgn; v.addr = addr;
      v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_fault = exp_fault; v.exp_lat = exp_lat;
      return v;
   endfunction

   // Drive one transaction at a negedge, scramble inputs after capture, then
   // count edges to the ack toggle (capture edge is T, lat = edges after T).
   task automatic run(input vec_t v, input bit use_b);
      logic ack0, ack_now, busy_now;
      logic [31:0] rd_now;
      logic flt_now;
      int n;
      @(negedge sck);
      if (!use_b) begin
         a_mode = v.mode; a_scale = v.scale; a_sgn = v.sgn; a_addr = v.addr; a_wdata = v.wdata;
         ack0 = a_ack; a_req = ~a_req;
      end else begin
         b_mode = v.mode; b_scale = v.scale; b_sgn = v.sgn; b_addr = v.addr; b_wdata = v.wdata;
         ack0 = b_ack; b_req = ~b_req;
      end
      n = 0;
      ack_now = ack0;
      while (ack_now == ack0 && n < 40) begin
         @(posedge sck);
         n++;
         #1;
         ack_now  = use_b ? b_ack : a_ack;
         busy_now = use_b ? b_busy : a_busy;
         if (n == 1) begin
            chk({v.name, "_busy_after_capture"}, {31'h0, busy_now}, 32'h1);
            if (!use_b) begin
               a_mode = ~v.mode; a_scale = 2'($urandom_range(0, 3)); a_sgn = ~v.sgn;
               a_addr = $urandom; a_wdata = $urandom;
            end else begin
               b_mode = ~v.mode; b_scale = 2'($urandom_range(0, 3)); b_sgn = ~v.sgn;
               b_addr = $urandom; b_wdata = $urandom;
            end
         end
      end
      rd_now   = use_b ? b_rdata : a_rdata;
      flt_now  = use_b ? b_fault : a_fault;
      busy_now = use_b ? b_busy : a_busy;
      chk({v.name, "_latency"}, 32'(n - 1), 32'(v.exp_lat));
      chk({v.name, "_rdata"}, rd_now, v.exp_rdata);
      chk({v.name, "_fault"}, {31'h0, flt_now}, {31'h0, v.exp_fault});
      chk({v.name, "_busy_clear"}, {31'h0, busy_now}, 32'h0);
   endtask

   initial begin
      a_rst = 1'b1; b_rst = 1'b1;
      a_req = 1'b0; a_mode = 1'b0; a_scale = 2'b00; a_sgn = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
      b_req = 1'b0; b_mode = 1'b0; b_scale = 2'b00; b_sgn = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;

      tbl.push_back(mk("w32_zero",    MEM_MODE_WRITE, MEM_SCALE_32BIT, 0, 32'h000, 32'h55AA55AA, 32'h0,        0, 3));
      tbl.push_back(mk("w32_word",    MEM_MODE_WRITE, MEM_SCALE_32BIT, 0, 32'h010, 32'h800000F0, 32'h0,        0, 3));
      tbl.push_back(mk("r32_word",    MEM_MODE_READ,  MEM_SCALE_32BIT, 1, 32'h010, 32'h0,        32'h800000F0, 0, 3));
      tbl.push_back(mk("w32_ext",     MEM_MODE_WRITE, MEM_SCALE_32BIT, 0, 32'h020, 32'h123480FF, 32'h0,        0, 3));
      tbl.push_back(mk("r8s_20",      MEM_MODE_READ,  MEM_SCALE_8BIT,  1, 32'h020, 32'h0,        32'hFFFFFFFF, 0, 3));
      tbl.push_back(mk("r8u_21",      MEM_MODE_READ,  MEM_SCALE_8BIT,  0, 32'h021, 32'h0,        32'h00000080, 0, 3));
      tbl.push_back(mk("r16s_22",     MEM_MODE_READ,  MEM_SCALE_16BIT, 1, 32'h022, 32'h0,        32'h00001234, 0, 3));
      tbl.push_back(mk("r16s_20",     MEM_MODE_READ,  MEM_SCALE_16BIT, 1, 32'h020, 32'h0,        32'hFFFF80FF, 0, 3));
      tbl.push_back(mk("r16u_20",     MEM_MODE_READ,  MEM_SCALE_16BIT, 0, 32'h020, 32'h0,        32'h000080FF, 0, 3));
      tbl.push_back(mk("w8_21",       MEM_MODE_WRITE, MEM_SCALE_8BIT,  0, 32'h021, 32'h000000AB, 32'h0,        0, 3));
      tbl.push_back(mk("r32_after_w8",MEM_MODE_READ,  MEM_SCALE_32BIT, 0, 32'h020, 32'h0,        32'h1234ABFF, 0, 3));
      tbl.push_back(mk("r8s_21",      MEM_MODE_READ,  MEM_SCALE_8BIT,  1, 32'h021, 32'h0,        32'hFFFFFFAB, 0, 3));
      tbl.push_back(mk("r8u_23",      MEM_MODE_READ,  MEM_SCALE_8BIT,  0, 32'h023, 32'h0,        32'h00000012, 0, 3));
      tbl.push_back(mk("r32_mis",     MEM_MODE_READ,  MEM_SCALE_32BIT, 0, 32'h012, 32'h0,        32'h0,        1, 2));
      tbl.push_back(mk("r16_mis",     MEM_MODE_READ,  MEM_SCALE_16BIT, 0, 32'h023, 32'h0,        32'h0,        1, 2));
      tbl.push_back(mk("w16_oor",     MEM_MODE_WRITE, MEM_SCALE_16BIT, 0, 32'h401, 32'h0000BEEF, 32'h0,        1, 2));
      tbl.push_back(mk("w32_oor",     MEM_MODE_WRITE, MEM_SCALE_32BIT, 0, 32'h400, 32'hDEADBEEF, 32'h0,        1, 2));
      tbl.push_back(mk("r32_zero",    MEM_MODE_READ,  MEM_SCALE_32BIT, 0, 32'h000, 32'h0,        32'h55AA55AA, 0, 3));
      tbl.push_back(mk("rd_rsvd",     MEM_MODE_READ,  MEM_SCALE_RSVD,  0, 32'h020, 32'h0,        32'h0,        1, 2));
      tbl.push_back(mk("wr_rsvd",     MEM_MODE_WRITE, MEM_SCALE_RSVD,  0, 32'h020, 32'h00000000, 32'h0,        1, 2));
      tbl.push_back(mk("r32_unchg",   MEM_MODE_READ,  MEM_SCALE_32BIT, 0, 32'h020, 32'h0,        32'h1234ABFF, 0, 3));
      tbl.push_back(mk("w16_hi",      MEM_MODE_WRITE, MEM_SCALE_16BIT, 0, 32'h002, 32'hFFFF7777, 32'h0,        0, 3));
      tbl.push_back(mk("r32_w16",     MEM_MODE_READ,  MEM_SCALE_32BIT, 0, 32'h000, 32'h0,        32'h777755AA, 0, 3));

      repeat (3) @(posedge sck);
      @(negedge sck);
      a_rst = 1'b0; b_rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         @(posedge sck);
         #1;
         chk("idle_ack", {31'h0, a_ack}, 32'h0);
         chk("idle_busy", {31'h0, a_busy}, 32'h0);
         chk("idle_rdata", a_rdata, 32'h0);
      end

      for (int i = 0; i < tbl.size(); i++) run(tbl[i], 1'b0);

      run(mk("b_w32",    MEM_MODE_WRITE, MEM_SCALE_32BIT, 0, 32'h030, 32'hCAFEF00D, 32'h0,        0, 6), 1'b1);
      run(mk("b_r32",    MEM_MODE_READ,  MEM_SCALE_32BIT, 0, 32'h030, 32'h0,        32'hCAFEF00D, 0, 6), 1'b1);
      run(mk("b_r32_mis",MEM_MODE_READ,  MEM_SCALE_32BIT, 0, 32'h031, 32'h0,        32'h0,        1, 2), 1'b1);
      run(mk("b_r32_2",  MEM_MODE_READ,  MEM_SCALE_32BIT, 0, 32'h030, 32'h0,        32'hCAFEF00D, 0, 6), 1'b1);

      // Reset three edges after capture of a write, before its commit edge.
      @(negedge sck);
      b_mode = MEM_MODE_WRITE; b_scale = MEM_SCALE_32BIT; b_sgn = 1'b0;
      b_addr = 32'h030; b_wdata = 32'h11111111; b_req = ~b_req;
      for (int i = 0; i < 3; i++) begin
         @(posedge sck);
         #1;
         chk("rst_pre_busy", {31'h0, b_busy}, 32'h1);
      end
      @(posedge sck);
      #1;
      b_rst = 1'b1;
      b_req = 1'b0;
      #1;
      chk("rst_ack", {31'h0, b_ack}, 32'h0);
      chk("rst_busy", {31'h0, b_busy}, 32'h0);
      chk("rst_rdata", b_rdata, 32'h0);
      chk("rst_fault", {31'h0, b_fault}, 32'h0);
      chk("rst_state", {30'h0, b_state}, {30'h0, ST_IDLE});
      repeat (2) @(posedge sck);
      @(negedge sck);
      b_rst = 1'b0;
      repeat (4) @(posedge sck);
      #1;
      chk("rst_no_ack", {31'h0, b_ack}, 32'h0);
      chk("rst_idle_busy", {31'h0, b_busy}, 32'h0);
      run(mk("b_r32_after_rst", MEM_MODE_READ, MEM_SCALE_32BIT, 0, 32'h030, 32'h0, 32'hCAFEF00D, 0, 6), 1'b1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/vmem_port.md
# vmem_port

Data-memory responder for the vcpu load/store path. Accepts one memory transaction at a time over the core's toggle request/acknowledge handshake and returns the response over the same handshake. Holds a word-organised local RAM and performs 8/16/32-bit reads with zero or sign extension, and byte-lane writes. Reports misaligned, out-of-range and reserved-scale accesses as faults.

## Interface
- `ADDR_BITS`, 10: byte-address width of the local RAM. Depth is 2^(ADDR_BITS-2) 32-bit words.
- `LATENCY`, 1: access cycles spent in ACCESS. Legal range is 1..15.
- `sck` input 1: the single clock. All state changes on the posedge.
- `rst` input 1: reset, asynchronous and active-high.
- `mem_req` input 1: request toggle. A request is pending when `mem_req != mem_ack`.
- `mem_mode` input 1: 0 = read, 1 = write.
- `mem_scale` input 2: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = reserved.
- `mem_is_signed` input 1: sign-extend on reads. Ignored for writes and 32-bit reads.
- `mem_addr` input 32: byte address.
- `mem_wdata` input 32: write data, taken from the low 8/16/32 bits.
- `mem_ack` output 1: acknowledge toggle.
- `mem_rdata` output 32: read result, valid when `mem_ack` toggles.
- `mem_fault` output 1: the access just acknowledged was rejected.
- `busy` output 1: high from the capture edge through the edge that toggles `mem_ack`.

## Operation
- States: IDLE, CHECK, ACCESS, RESP.
- **IDLE**
  - When `mem_req != mem_ack`: latch mode, scale, signed, addr and wdata; set `busy` = 1; go to CHECK.
  - Inputs are sampled only at this edge. Later changes to them are ignored.
- **CHECK:** a fault is raised for any of:
  - scale = 11;
  - 16-bit access with addr[0] = 1;
  - 32-bit access with addr[1:0] != 0;
  - addr >= 2^ADDR_BITS (any set bit in addr[31:ADDR_BITS]).
- **CHECK transitions**
  - Fault: go to RESP with `fault_nxt` = 1 and `rdata_nxt` = 0.
  - No fault: go to ACCESS with cnt = LATENCY-1.
- **ACCESS**
  - While cnt != 0: decrement cnt.
  - When cnt == 0, the word index is addr[ADDR_BITS-1:2], then go to RESP.
  - Read, 8-bit: byte lane selected by addr[1:0].
  - Read, 16-bit: halfword selected by addr[1].
  - Read, 32-bit: whole word.
  - Reads are then zero- or sign-extended to 32 bits into `rdata_nxt`.
  - Write, 8-bit: one byte lane enabled, carrying wdata[7:0].
  - Write, 16-bit: two lanes enabled, carrying wdata[15:0].
  - Write, 32-bit: all four lanes enabled.
  - A write commits at this edge, and `rdata_nxt` = 0 for writes.
- **RESP:** `mem_ack` <= ~`mem_ack`; `mem_rdata` <= `rdata_nxt`; `mem_fault` <= `fault_nxt`; `busy` <= 0; go to IDLE.
- A faulted write never modifies the RAM.
- There is one outstanding transaction at most. The initiator must not toggle `mem_req` again before `mem_ack` toggles. A request made while busy is not detected until IDLE, because detection is the `mem_req != mem_ack` comparison.

## Timing
- **Reset values:** `mem_ack` = 0, `mem_rdata` = 0, `mem_fault` = 0, `busy` = 0, state = IDLE, cnt = 0. RAM contents are not reset.
- **Good access:** with capture at edge T, `mem_ack` toggles at edge T+2+LATENCY (LATENCY = 1 gives T+3). A write is visible in the RAM from edge T+1+LATENCY.
- **Faulted access:** `mem_ack` toggles at edge T+2.
- `mem_rdata` and `mem_fault` change only on the edge that toggles `mem_ack`, and hold their values until the next acknowledge.
- **Back-to-back requests:** if `mem_req` toggles in the cycle after acknowledge, capture happens on the first IDLE edge. Minimum spacing between acknowledges is LATENCY+3 cycles.
- **Reset mid-transaction:** returns to IDLE immediately with no acknowledge. A write commits only if its ACCESS commit edge occurred before `rst` rose. After reset, `mem_ack` = 0. The initiator must also clear `mem_req` to 0; otherwise a stale pending request is seen.

## Structure
- Shared package `vcpu_pkg` holds:
  - `MEM_MODE_READ`/`MEM_MODE_WRITE` (1'b0/1'b1);
  - `MEM_SCALE_8BIT`/`16BIT`/`32BIT` (2'b00/01/10), plus `MEM_SCALE_RSVD` 2'b11;
  - the state enum for IDLE/CHECK/ACCESS/RESP.
- One sub-module is natural: `vmem_lane_align`, purely combinational.
  - Read path: word + addr[1:0] + scale + signed -> extended 32-bit data.
  - Write path: addr[1:0] + scale + wdata -> 4-bit byte enable + lane-replicated write word.
- The top level holds the FSM, the latency counter, the RAM array and the output registers.

## Test plan
- **Reset, then idle:** hold `mem_req` = 0 -> `mem_ack` = 0, `busy` = 0 and `mem_rdata` = 0 throughout.
- **Word round trip:**
  - Write 32-bit 0x8000_00F0 to addr 0x10 -> ack at T+3, `mem_fault` = 0.
  - 32-bit read of 0x10 -> 0x8000_00F0.
- **Byte and halfword extension, memory word 0x1234_80FF at 0x20:**
  - Signed 8-bit read of 0x20 -> 0xFFFF_FFFF.
  - Unsigned 8-bit read of 0x21 -> 0x0000_0080.
  - Signed 16-bit read of 0x22 -> 0x0000_1234.
  - Signed 16-bit read of 0x20 -> 0xFFFF_80FF.
- **Byte-lane write:**
  - 8-bit write of 0xAB to 0x21 over 0x1234_80FF -> a subsequent 32-bit read returns 0x1234_ABFF.
- **Faults:**
  - 32-bit read of 0x12 -> ack at T+2, `mem_fault` = 1, `mem_rdata` = 0.
  - 16-bit write of 0x0000_0401 (with ADDR_BITS = 10) -> fault, and the RAM is unchanged.
  - Scale 11 -> fault.
- **Latency and reset:**
  - With LATENCY = 4, a write captured at T acknowledges at T+6.
  - Assert `rst` at T+3 on a write -> no ack, the RAM is unchanged, and all outputs return to their reset values.
